axis_packet_arbiter: RTL and testbench

AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

---
 rtl/compair_axis_arb_pkg.sv | 33 +++
 rtl/rr_priority_encoder.sv | 40 ++++
 rtl/axis_packet_arbiter.sv | 147 ++++++++++++++
 tb/tb_axis_packet_arbiter.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compair_axis_arb_pkg.sv
// Shared definitions for the AXI-Stream packet arbiter.
//   arb_state_t  : arbiter FSM states (IDLE waits for a requester, BUSY streams one packet)
//   BEAT_CNT_W   : width of the per-packet beat counter
//   IDX_MAX_W    : widest source index the debug struct can carry (up to 8 sources)
//   arb_dbg_t    : observation struct exported by the top level
//   clog2()      : index width for a given source count, never less than 1
package compair_axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int BEAT_CNT_W = 16;
    localparam int IDX_MAX_W  = 3;

    typedef struct packed {
        arb_state_t            state;
        logic [IDX_MAX_W-1:0]  rr_ptr;
        logic [IDX_MAX_W-1:0]  grant;
        logic [BEAT_CNT_W-1:0] beat_cnt;
    } arb_dbg_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Rotating priority encoder.
//   req       : request vector, one bit per source
//   ptr       : index that currently has the highest priority
//   gnt_idx   : first requesting index found searching upward from ptr, wrapping N-1 -> 0
//   gnt_valid : at least one request is present
module rr_priority_encoder #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    int             sum;

    // Rotate the requests so that bit 0 of req_rot is source ptr; the lowest
    // set bit of req_rot is then the winner, offset back by ptr modulo N.
    always_comb begin
        req_dbl   = {req, req} >> ptr;
        req_rot   = req_dbl[N-1:0];
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        sum       = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sum = int'(ptr) + i;
                if (sum >= N) begin
                    sum = sum - N;
                end
                gnt_idx   = IDX_W'(sum);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter merging N_SRC AXI-Stream sources into one
// stream toward a shared FIFO.
//   aclk, aresetn   : clock and asynchronous active-low reset
//   s_axis_*        : source streams, source i data at [i*DWIDTH +: DWIDTH]
//   m_axis_*        : merged stream; m_axis_tid carries the granted source index
//   src_enable      : per-source arbitration enable (does not break a running packet)
//   err_clear       : pulse clearing err_truncated
//   err_truncated   : sticky flag per source whose packet was cut at MAX_BEATS
//   dbg_status      : FSM state, rotation pointer, grant and beat counter
//
// Handshake: a beat moves on a rising edge when tvalid and tready are both
// high; a source keeps tvalid and its data stable until accepted. While BUSY
// the granted source is wired straight through, so s_axis_tready[grant]
// follows m_axis_tready and every other source sees tready low.
module axis_packet_arbiter
    import compair_axis_arb_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DWIDTH    = 8,
    parameter int TID_WIDTH = 8,
    parameter int MAX_BEATS = 256
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [N_SRC*DWIDTH-1:0] s_axis_tdata,
    input  logic [N_SRC-1:0]        s_axis_tvalid,
    input  logic [N_SRC-1:0]        s_axis_tlast,
    output logic [N_SRC-1:0]        s_axis_tready,
    output logic [DWIDTH-1:0]       m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [TID_WIDTH-1:0]    m_axis_tid,
    input  logic [N_SRC-1:0]        src_enable,
    input  logic                    err_clear,
    output logic [N_SRC-1:0]        err_truncated,
    output arb_dbg_t                dbg_status
);

    localparam int IDX_W = clog2(N_SRC);
    localparam logic [BEAT_CNT_W-1:0] LIMIT_IDX = BEAT_CNT_W'(MAX_BEATS - 1);

    arb_state_t            state;
    logic [IDX_W-1:0]      grant;
    logic [IDX_W-1:0]      rr_ptr;
    logic [BEAT_CNT_W-1:0] beat_cnt;

    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_valid;
    logic [IDX_W-1:0]      rr_next;

    logic [DWIDTH-1:0]     src_data;
    logic                  src_valid;
    logic                  src_last;
    logic                  busy;
    logic                  at_limit;
    logic                  beat_hs;
    logic                  trunc_evt;

    rr_priority_encoder #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (s_axis_tvalid & src_enable),
        .ptr       (rr_ptr),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign rr_next = (gnt_idx == IDX_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;

    // Select the granted source's signals.
    always_comb begin
        src_data  = '0;
        src_valid = 1'b0;
        src_last  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant == IDX_W'(i)) begin
                src_data  = s_axis_tdata[i*DWIDTH +: DWIDTH];
                src_valid = s_axis_tvalid[i];
                src_last  = s_axis_tlast[i];
            end
        end
    end

    assign busy     = (state == BUSY);
    // beat_cnt counts beats already accepted, so the beat on the bus now is
    // number beat_cnt+1; it is the last allowed one when beat_cnt == MAX_BEATS-1.
    assign at_limit = (beat_cnt == LIMIT_IDX);

    assign m_axis_tvalid = busy & src_valid;
    assign m_axis_tdata  = busy ? src_data : '0;
    assign m_axis_tlast  = busy & (src_last | at_limit);
    assign m_axis_tid    = busy ? TID_WIDTH'(grant) : '0;
    assign s_axis_tready = busy ? (N_SRC'(m_axis_tready) << grant) : '0;

    assign beat_hs   = m_axis_tvalid & m_axis_tready;
    assign trunc_evt = beat_hs & ~src_last & at_limit;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        state    <= BUSY;
                        grant    <= gnt_idx;
                        rr_ptr   <= rr_next;
                        beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (beat_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (m_axis_tlast) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A clear coinciding with a truncation wins: the flag ends up cleared.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_truncated <= '0;
        end else if (err_clear) begin
            err_truncated <= '0;
        end else if (trunc_evt) begin
            err_truncated <= err_truncated | (N_SRC'(1) << grant);
        end
    end

    always_comb begin
        dbg_status.state    = state;
        dbg_status.rr_ptr   = IDX_MAX_W'(rr_ptr);
        dbg_status.grant    = IDX_MAX_W'(grant);
        dbg_status.beat_cnt = beat_cnt;
    end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
module tb_axis_packet_arbiter;
    import compair_axis_arb_pkg::*;

    localparam int NS   = 4;
    localparam int DW   = 8;
    localparam int TW   = 8;
    localparam int MAXB = 4;
    localparam int MEMD = 32;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [NS*DW-1:0] s_axis_tdata;
    logic [NS-1:0]    s_axis_tvalid;
    logic [NS-1:0]    s_axis_tlast;
    logic [NS-1:0]    s_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic             m_axis_tlast;
    logic [TW-1:0]    m_axis_tid;
    logic [NS-1:0]    src_enable;
    logic             err_clear;
    logic [NS-1:0]    err_truncated;
    arb_dbg_t         dbg_status;

    axis_packet_arbiter #(
        .N_SRC     (NS),
        .DWIDTH    (DW),
        .TID_WIDTH (TW),
        .MAX_BEATS (MAXB)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .src_enable    (src_enable),
        .err_clear     (err_clear),
        .err_truncated (err_truncated),
        .dbg_status    (dbg_status)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    // ---------------- bench state ----------------
    logic [8:0]  src_mem [NS][MEMD];   // {last, data} per beat
    int          wr_ptr [NS];
    int          rd_ptr [NS];
    logic [16:0] exp_q[$];             // {tid, data, last}
    logic [3:0]  exp_err;
    int          checks   = 0;
    int          failures = 0;

    int          tready_pct;
    int          stall_at;
    int          stall_len;
    int          stall_cnt;
    int          drop_en0_at;
    bit          clear_on_trunc;
    bit          check_ptr2;
    int          beats_seen;

    task automatic do_reset();
        aresetn       = 1'b0;
        err_clear     = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NS; i++) begin
            wr_ptr[i] = 0;
            rd_ptr[i] = 0;
        end
        exp_q.delete();
        exp_err        = '0;
        tready_pct     = 100;
        stall_at       = -1;
        stall_len      = 0;
        stall_cnt      = 0;
        drop_en0_at    = -1;
        clear_on_trunc = 1'b0;
        check_ptr2     = 1'b0;
        beats_seen     = 0;
    endtask

    task automatic add_packet(input int src, input int len);
        for (int b = 0; b < len; b++) begin
            if (wr_ptr[src] < MEMD) begin
                src_mem[src][wr_ptr[src]] = {(b == len - 1), 8'($urandom_range(0, 255))};
                wr_ptr[src] = wr_ptr[src] + 1;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_inputs();
        for (int i = 0; i < NS; i++) begin
            if (rd_ptr[i] < wr_ptr[i]) begin
                s_axis_tvalid[i]          = 1'b1;
                s_axis_tlast[i]           = src_mem[i][rd_ptr[i]][8];
                s_axis_tdata[i*DW +: DW]  = src_mem[i][rd_ptr[i]][7:0];
            end else begin
                s_axis_tvalid[i]          = 1'b0;
                s_axis_tlast[i]           = 1'b0;
                s_axis_tdata[i*DW +: DW]  = '0;
            end
        end
        if (stall_at >= 0 && beats_seen == stall_at && stall_cnt < stall_len) begin
            m_axis_tready = 1'b0;
            stall_cnt     = stall_cnt + 1;
        end else begin
            m_axis_tready = ($urandom_range(0, 99) < tready_pct);
        end
    endtask

    // ---------------- reference model ----------------
    // Packet-level view: every loaded beat is valid from the start, so the
    // order is fixed by the rotation rule alone. Each grant takes up to MAXB
    // beats of the winner's packet; a cut packet leaves its tail for later.
    task automatic build_expected(input logic [3:0] en_first, input logic [3:0] en_rest);
        int         r [NS];
        int         ptr;
        int         w;
        int         n;
        bit         first;
        bit         done;
        logic [8:0] beat;
        logic [3:0] en;
        for (int i = 0; i < NS; i++) r[i] = rd_ptr[i];
        ptr   = 0;
        first = 1'b1;
        forever begin
            en = first ? en_first : en_rest;
            w  = -1;
            for (int k = 0; k < NS; k++) begin
                int idx;
                idx = (ptr + k) % NS;
                if (w < 0 && en[idx] && r[idx] < wr_ptr[idx]) w = idx;
            end
            if (w < 0) break;
            n    = 0;
            done = 1'b0;
            while (!done) begin
                beat = src_mem[w][r[w]];
                r[w] = r[w] + 1;
                n    = n + 1;
                if (beat[8]) begin
                    exp_q.push_back({8'(w), beat[7:0], 1'b1});
                    done = 1'b1;
                end else if (n == MAXB) begin
                    exp_q.push_back({8'(w), beat[7:0], 1'b1});
                    exp_err[w] = 1'b1;
                    done = 1'b1;
                end else begin
                    exp_q.push_back({8'(w), beat[7:0], 1'b0});
                end
                if (r[w] >= wr_ptr[w]) done = 1'b1;
            end
            ptr   = (w + 1) % NS;
            first = 1'b0;
        end
    endtask

    // ---------------- monitor + scoreboard loop ----------------
    task automatic run(input int max_cycles, input int stop_beats);
        int          quiet;
        int          gap;
        bit          after_last;
        bit          prev_stall;
        logic [17:0] prev_snap;
        logic [16:0] got;
        logic [16:0] exp;
        logic [3:0]  consumed;
        logic [3:0]  exp_rdy;
        quiet      = 0;
        gap        = 0;
        after_last = 1'b0;
        prev_stall = 1'b0;
        prev_snap  = '0;
        drive_inputs();
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            @(negedge aclk);
            consumed = s_axis_tvalid & s_axis_tready;
            if (m_axis_tvalid) begin
                exp_rdy = 4'(m_axis_tready) << m_axis_tid[1:0];
                checks++;
                if (s_axis_tready !== exp_rdy) begin
                    failures++;
                    $display("FAIL src_ready_routing got=%b exp=%b", s_axis_tready, exp_rdy);
                end
            end
            if (prev_stall) begin
                checks++;
                if ({m_axis_tvalid, m_axis_tdata, m_axis_tid, m_axis_tlast} !== prev_snap) begin
                    failures++;
                    $display("FAIL hold_under_backpressure got=%h exp=%h",
                             {m_axis_tvalid, m_axis_tdata, m_axis_tid, m_axis_tlast}, prev_snap);
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_snap  = {m_axis_tvalid, m_axis_tdata, m_axis_tid, m_axis_tlast};
            if (m_axis_tvalid) begin
                if (after_last) begin
                    checks++;
                    if (gap != 1) begin
                        failures++;
                        $display("FAIL idle_gap got=%0d exp=1", gap);
                    end
                    after_last = 1'b0;
                end
            end else if (after_last) begin
                gap++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got = {m_axis_tid, m_axis_tdata, m_axis_tlast};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_beat got=%h exp=none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL beat tid/data/last got=%h exp=%h", got, exp);
                    end
                end
                if (check_ptr2) begin
                    checks++;
                    if (dbg_status.rr_ptr !== 3'd3) begin
                        failures++;
                        $display("FAIL rr_ptr_after_src2 got=%0d exp=3", dbg_status.rr_ptr);
                    end
                end
                if (clear_on_trunc && m_axis_tlast && m_axis_tid < 8'(NS)) begin
                    if (!src_mem[m_axis_tid[1:0]][rd_ptr[m_axis_tid[1:0]]][8]) err_clear = 1'b1;
                end
                beats_seen++;
                if (m_axis_tlast && exp_q.size() > 0) begin
                    after_last = 1'b1;
                    gap        = 0;
                end
            end
            @(posedge aclk);
            #1;
            err_clear = 1'b0;
            for (int i = 0; i < NS; i++) begin
                if (consumed[i]) rd_ptr[i] = rd_ptr[i] + 1;
            end
            if (drop_en0_at >= 0 && beats_seen == drop_en0_at) src_enable[0] = 1'b0;
            drive_inputs();
            if (stop_beats > 0 && beats_seen >= stop_beats) return;
            if (exp_q.size() == 0) begin
                quiet++;
                if (quiet > 6) return;
            end
        end
        checks++;
        failures++;
        $display("FAIL run_timeout got=%0d_beats_left exp=0", exp_q.size());
    endtask

    task automatic check_end(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_beats_missing got=%0d exp=0", name, exp_q.size());
        end
        checks++;
        if (err_truncated !== exp_err) begin
            failures++;
            $display("FAIL %s_err_truncated got=%b exp=%b", name, err_truncated, exp_err);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        aresetn = 1'b0;
        clear_sources();
        src_enable = 4'hf;
        err_clear  = 1'b0;
        for (int i = 0; i < NS; i++) add_packet(i, 3);
        drive_inputs();
        @(negedge aclk);
        @(negedge aclk);
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tid} !== 18'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tid});
        end
        checks++;
        if (s_axis_tready !== 4'd0) begin
            failures++;
            $display("FAIL reset_src_ready got=%b exp=0000", s_axis_tready);
        end
        checks++;
        if (err_truncated !== 4'd0) begin
            failures++;
            $display("FAIL reset_err got=%b exp=0000", err_truncated);
        end
        checks++;
        if (dbg_status.state !== IDLE || dbg_status.rr_ptr !== 3'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d/%0d exp=0/0", dbg_status.state, dbg_status.rr_ptr);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_round_robin();
        do_reset();
        clear_sources();
        src_enable = 4'hf;
        for (int i = 0; i < NS; i++) add_packet(i, 3);
        build_expected(4'hf, 4'hf);
        run(300, 0);
        check_end("round_robin");
    endtask

    task automatic test_single_source();
        do_reset();
        clear_sources();
        src_enable = 4'hf;
        for (int p = 0; p < 6; p++) add_packet(2, 2);
        tready_pct = 80;
        check_ptr2 = 1'b1;
        build_expected(4'hf, 4'hf);
        run(400, 0);
        check_end("single_source");
    endtask

    task automatic test_truncation();
        do_reset();
        clear_sources();
        src_enable = 4'hf;
        add_packet(1, 6);
        build_expected(4'hf, 4'hf);
        run(200, 0);
        check_end("truncation");
        @(negedge aclk);
        err_clear = 1'b1;
        @(posedge aclk);
        #1;
        err_clear = 1'b0;
        @(negedge aclk);
        checks++;
        if (err_truncated !== 4'd0) begin
            failures++;
            $display("FAIL err_clear got=%b exp=0000", err_truncated);
        end
        // clear pulse landing on the truncating beat must win
        clear_sources();
        add_packet(1, 6);
        clear_on_trunc = 1'b1;
        build_expected(4'hf, 4'hf);
        exp_err = 4'd0;
        run(200, 0);
        check_end("clear_vs_truncation");
    endtask

    task automatic test_backpressure();
        do_reset();
        clear_sources();
        src_enable = 4'hf;
        add_packet(0, 2);
        add_packet(3, 4);
        stall_at  = 4;
        stall_len = 10;
        build_expected(4'hf, 4'hf);
        run(300, 0);
        check_end("backpressure");
        checks++;
        if (stall_cnt != 10) begin
            failures++;
            $display("FAIL stall_cycles got=%0d exp=10", stall_cnt);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        clear_sources();
        src_enable = 4'hf;
        add_packet(0, 3);
        add_packet(0, 3);
        add_packet(1, 2);
        drop_en0_at = 1;
        build_expected(4'hf, 4'he);
        run(300, 0);
        check_end("enable_drop");
        checks++;
        if (rd_ptr[0] != 3) begin
            failures++;
            $display("FAIL src0_beats_taken got=%0d exp=3", rd_ptr[0]);
        end
        src_enable = 4'hf;
    endtask

    task automatic test_random();
        logic [3:0] en;
        for (int round = 0; round < 5; round++) begin
            do_reset();
            clear_sources();
            en = 4'($urandom_range(1, 15));
            src_enable = en;
            for (int i = 0; i < NS; i++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) add_packet(i, $urandom_range(1, 6));
            end
            tready_pct = $urandom_range(50, 100);
            build_expected(en, en);
            run(2000, 0);
            check_end("random");
        end
        src_enable = 4'hf;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        clear_sources();
        src_enable = 4'hf;
        add_packet(1, 5);
        add_packet(2, 2);
        add_packet(3, 2);
        build_expected(4'hf, 4'hf);
        run(100, 1);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tid} !== 18'd0 || s_axis_tready !== 4'd0) begin
            failures++;
            $display("FAIL async_reset_outputs got=%h exp=0",
                     {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tid, s_axis_tready});
        end
        checks++;
        if (dbg_status.rr_ptr !== 3'd0 || dbg_status.state !== IDLE || err_truncated !== 4'd0) begin
            failures++;
            $display("FAIL async_reset_state got=%0d/%0d/%b exp=0/0/0000",
                     dbg_status.rr_ptr, dbg_status.state, err_truncated);
        end
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        // source 1 keeps offering beats 2..5 from where it was cut off
        exp_q.delete();
        exp_err    = '0;
        beats_seen = 0;
        build_expected(4'hf, 4'hf);
        checks++;
        if (exp_q.size() == 0 || exp_q[0][16:9] != 8'd1) begin
            failures++;
            $display("FAIL model_first_after_reset got=%0d exp=1", exp_q.size());
        end
        run(300, 0);
        check_end("reset_mid_packet");
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_round_robin();
        test_single_source();
        test_truncation();
        test_backpressure();
        test_enable_drop();
        test_random();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
